// File: rtl/div_share_ctrl_pkg.sv
// rtl/div_share_ctrl_pkg.sv - shared state encoding, field widths and operand record for div_share_ctrl
package div_share_ctrl_pkg;

   // Width of dividend, divisor, quotient and remainder.
   localparam int DIV_DATA_W = 32;

   // Default width of the instruction tag carried alongside an operation.
   localparam int DIV_TAG_W = 4;

   // Controller FSM encoding.
   localparam logic [1:0] DIV_S_IDLE  = 2'd0;
   localparam logic [1:0] DIV_S_ISSUE = 2'd1;
   localparam logic [1:0] DIV_S_BUSY  = 2'd2;
   localparam logic [1:0] DIV_S_DONE  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = DIV_S_IDLE,
      ST_ISSUE = DIV_S_ISSUE,
      ST_BUSY  = DIV_S_BUSY,
      ST_DONE  = DIV_S_DONE
   } div_state_e;

   // Operands latched from the winning requester.
   typedef struct packed {
      logic                  sgn;
      logic [DIV_DATA_W-1:0] x;
      logic [DIV_DATA_W-1:0] y;
   } div_opnd_t;

endpackage

// File: rtl/div_share_ctrl_rr_arb2.sv
// rtl/div_share_ctrl_rr_arb2.sv - two-requester round-robin arbiter holding the rr_ptr register
module div_share_ctrl_rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic valid0,
   input  logic valid1,
   input  logic advance,
   output logic grant0,
   output logic grant1
);

   logic rr_ptr_q;
   logic rr_ptr_d;

   // A lone requester always wins; a contested grant goes to rr_ptr, which then flips.
   always_comb begin
      grant0   = valid0 & (~valid1 | ~rr_ptr_q);
      grant1   = valid1 & (~valid0 |  rr_ptr_q);
      rr_ptr_d = rr_ptr_q;
      if (advance && valid0 && valid1) begin
         rr_ptr_d = ~rr_ptr_q;
      end
   end

   // Priority pointer register; slot 0 preferred out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/div_share_ctrl.sv
// rtl/div_share_ctrl.sv - shares one iterative divider between two issue slots; DIV_ZERO_BYPASS_EN short-circuits y==0
module div_share_ctrl
   import div_share_ctrl_pkg::*;
#(
   parameter int TAG_W = DIV_TAG_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  req0_valid,
   input  logic                  req0_signed,
   input  logic [DIV_DATA_W-1:0] req0_x,
   input  logic [DIV_DATA_W-1:0] req0_y,
   input  logic [TAG_W-1:0]      req0_tag,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic                  req1_signed,
   input  logic [DIV_DATA_W-1:0] req1_x,
   input  logic [DIV_DATA_W-1:0] req1_y,
   input  logic [TAG_W-1:0]      req1_tag,
   output logic                  req1_ready,
   output logic                  div_req,
   output logic                  div_signed,
   output logic [DIV_DATA_W-1:0] div_x,
   output logic [DIV_DATA_W-1:0] div_y,
   output logic                  div_cancel,
   input  logic                  div_oprand_ok,
   input  logic                  div_data_ok,
   input  logic [DIV_DATA_W-1:0] div_quot,
   input  logic [DIV_DATA_W-1:0] div_rem,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic                  resp_src,
   output logic [TAG_W-1:0]      resp_tag,
   output logic [DIV_DATA_W-1:0] resp_quot,
   output logic [DIV_DATA_W-1:0] resp_rem,
   output logic                  busy
);

   div_state_e            state_q, state_d;
   div_opnd_t             op_q, op_d;
   logic [TAG_W-1:0]      op_tag_q, op_tag_d;
   logic                  op_src_q, op_src_d;
   logic [DIV_DATA_W-1:0] res_quot_q, res_quot_d;
   logic [DIV_DATA_W-1:0] res_rem_q, res_rem_d;

   logic arb_adv;
   logic arb_g0;
   logic arb_g1;

   // Arbitration only counts in IDLE with no flush, so rr_ptr flips only on a real grant.
   assign arb_adv = (state_q == ST_IDLE) & ~flush;

   div_share_ctrl_rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid0  (req0_valid),
      .valid1  (req1_valid),
      .advance (arb_adv),
      .grant0  (arb_g0),
      .grant1  (arb_g1)
   );

   // Next state, operand/result capture and request handshakes; flush overrides everything.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      op_tag_d   = op_tag_q;
      op_src_d   = op_src_q;
      res_quot_d = res_quot_q;
      res_rem_d  = res_rem_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      div_cancel = 1'b0;
      if (flush) begin
         state_d    = ST_IDLE;
         div_cancel = (state_q == ST_ISSUE) || (state_q == ST_BUSY);
      end else begin
         case (state_q)
            ST_IDLE: begin
               req0_ready = arb_g0;
               req1_ready = arb_g1;
               if (arb_g0 || arb_g1) begin
                  op_src_d = arb_g1;
                  op_d.sgn = arb_g1 ? req1_signed : req0_signed;
                  op_d.x   = arb_g1 ? req1_x      : req0_x;
                  op_d.y   = arb_g1 ? req1_y      : req0_y;
                  op_tag_d = arb_g1 ? req1_tag    : req0_tag;
                  state_d  = ST_ISSUE;
`ifdef DIV_ZERO_BYPASS_EN
                  if (op_d.y == '0) begin
                     res_quot_d = '1;
                     res_rem_d  = op_d.x;
                     state_d    = ST_DONE;
                  end
`endif
               end
            end
            ST_ISSUE: begin
               if (div_oprand_ok) begin
                  state_d = ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (div_data_ok) begin
                  res_quot_d = div_quot;
                  res_rem_d  = div_rem;
                  state_d    = ST_DONE;
               end
            end
            ST_DONE: begin
               if (resp_ready) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // FSM state plus the operand and result holding registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         op_q       <= '0;
         op_tag_q   <= '0;
         op_src_q   <= 1'b0;
         res_quot_q <= '0;
         res_rem_q  <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         op_tag_q   <= op_tag_d;
         op_src_q   <= op_src_d;
         res_quot_q <= res_quot_d;
         res_rem_q  <= res_rem_d;
      end
   end

   assign div_req    = (state_q == ST_ISSUE);
   assign div_signed = op_q.sgn;
   assign div_x      = op_q.x;
   assign div_y      = op_q.y;
   assign resp_valid = (state_q == ST_DONE);
   assign resp_src   = op_src_q;
   assign resp_tag   = op_tag_q;
   assign resp_quot  = res_quot_q;
   assign resp_rem   = res_rem_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb/tb_div_share_ctrl.sv - self-checking bench for div_share_ctrl with divider and reference models
module tb_div_share_ctrl;
   localparam int TAG_W = 4;
   localparam int LIMIT = 400;

   logic clk, rst, flush;
   logic req0_valid, req0_signed, req0_ready;
   logic [31:0] req0_x, req0_y;
   logic [TAG_W-1:0] req0_tag;
   logic req1_valid, req1_signed, req1_ready;
   logic [31:0] req1_x, req1_y;
   logic [TAG_W-1:0] req1_tag;
   logic div_req, div_signed, div_cancel, div_oprand_ok, div_data_ok;
   logic [31:0] div_x, div_y, div_quot, div_rem;
   logic resp_valid, resp_ready, resp_src, busy;
   logic [TAG_W-1:0] resp_tag;
   logic [31:0] resp_quot, resp_rem;

   div_share_ctrl #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req0_valid(req0_valid), .req0_signed(req0_signed), .req0_x(req0_x), .req0_y(req0_y),
      .req0_tag(req0_tag), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_signed(req1_signed), .req1_x(req1_x), .req1_y(req1_y),
      .req1_tag(req1_tag), .req1_ready(req1_ready),
      .div_req(div_req), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
      .div_cancel(div_cancel), .div_oprand_ok(div_oprand_ok), .div_data_ok(div_data_ok),
      .div_quot(div_quot), .div_rem(div_rem),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_src(resp_src), .resp_tag(resp_tag),
      .resp_quot(resp_quot), .resp_rem(resp_rem), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int               slot;
      logic             sgn;
      logic [31:0]      x;
      logic [31:0]      y;
      logic [TAG_W-1:0] tag;
      logic [31:0]      q;
      logic [31:0]      r;
   } vec_t;

   int n_vec, n_err, cyc;
   // divider model
   bit dv_busy, force_data_ok;
   int dv_cnt, dv_lat, dv_wait, dv_acc_delay, n_opok;
   logic [31:0] dv_q, dv_r;
   // reference model of the controller, transaction level
   bit rm_active, rm_issued, rm_have, rm_rr, rm_src, rm_sgn;
   logic [31:0] rm_x, rm_y, rm_q, rm_r;
   logic [TAG_W-1:0] rm_tag;
   // hooks and observations
   bit flush_on_data, flush_on_done, hook_fired;
   bit last_acc0, last_acc1, last_cancel, seen_div_req;
   int n_rv, n_resp;
   int glog[$];
   int gcyc[$];
   int hcyc[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Architectural division result; y==0 gives all-ones quotient and the dividend as remainder.
   function automatic void div_ref(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] q, output logic [31:0] r);
      if (y == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = x;
      end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (sgn) begin
         q = $signed(x) / $signed(y);
         r = $signed(x) % $signed(y);
      end else begin
         q = x / y;
         r = x % y;
      end
   endfunction

   task automatic div_step();
      div_oprand_ok = 1'b0;
      div_data_ok   = 1'b0;
      div_quot      = 32'hDEAD_BEEF;
      div_rem       = 32'hDEAD_BEEF;
      if (dv_busy) begin
         if (dv_cnt == 0) begin
            div_data_ok = 1'b1;
            div_quot    = dv_q;
            div_rem     = dv_r;
            dv_busy     = 1'b0;
         end else begin
            dv_cnt--;
         end
      end else if (div_req) begin
         if (dv_wait == 0) begin
            div_oprand_ok = 1'b1;
            div_ref(div_signed, div_x, div_y, dv_q, dv_r);
            dv_busy = 1'b1;
            dv_cnt  = dv_lat;
            dv_wait = dv_acc_delay;
            n_opok++;
         end else begin
            dv_wait--;
         end
      end
      if (force_data_ok && !div_data_ok) begin
         div_data_ok = 1'b1;
         div_quot    = 32'h1234_5678;
         div_rem     = 32'h8765_4321;
      end
      if (div_cancel) begin
         dv_busy = 1'b0;
         dv_wait = dv_acc_delay;
      end
   endtask

   task automatic ref_step();
      bit g0, g1, both;
      g0 = 1'b0;
      g1 = 1'b0;
      both = req0_valid && req1_valid;
      if (!rm_active && !flush) begin
         if (both) begin
            g0 = !rm_rr;
            g1 = rm_rr;
         end else begin
            g0 = req0_valid;
            g1 = req1_valid;
         end
      end
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      chk("busy", busy, rm_active);
      chk("resp_valid", resp_valid, rm_have);
      chk("div_req", div_req, rm_active && !rm_issued);
      chk("div_cancel", div_cancel, flush && rm_active && !rm_have);
      if (rm_active && !rm_issued) begin
         chk("div_x", div_x, rm_x);
         chk("div_y", div_y, rm_y);
         chk("div_signed", div_signed, rm_sgn);
      end
      if (rm_have) begin
         chk("resp_src", resp_src, rm_src);
         chk("resp_tag", resp_tag, rm_tag);
         chk("resp_quot", resp_quot, rm_q);
         chk("resp_rem", resp_rem, rm_r);
      end
      if (flush) begin
         rm_active = 1'b0;
         rm_issued = 1'b0;
         rm_have   = 1'b0;
      end else if (!rm_active) begin
         if (g0 || g1) begin
            if (both) rm_rr = !rm_rr;
            rm_src = g1;
            rm_sgn = g1 ? req1_signed : req0_signed;
            rm_x   = g1 ? req1_x : req0_x;
            rm_y   = g1 ? req1_y : req0_y;
            rm_tag = g1 ? req1_tag : req0_tag;
            div_ref(rm_sgn, rm_x, rm_y, rm_q, rm_r);
            rm_active = 1'b1;
            rm_issued = 1'b0;
            rm_have   = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
            if (rm_y == 32'd0) begin
               rm_issued = 1'b1;
               rm_have   = 1'b1;
            end
`endif
         end
      end else if (!rm_issued) begin
         if (div_oprand_ok) rm_issued = 1'b1;
      end else if (!rm_have) begin
         if (div_data_ok) rm_have = 1'b1;
      end else if (resp_ready) begin
         rm_active = 1'b0;
         rm_issued = 1'b0;
         rm_have   = 1'b0;
      end
   endtask

   // One clock cycle: divider model, checks, reference update, then advance to just after the edge.
   task automatic tick();
      bit fired;
      fired = 1'b0;
      #1;
      div_step();
      if (flush_on_data && div_data_ok) begin
         flush = 1'b1;
         dv_busy = 1'b0;
         fired = 1'b1;
      end
      if (flush_on_done && rm_have && resp_ready) begin
         flush = 1'b1;
         fired = 1'b1;
      end
      #1;
      last_acc0   = req0_ready;
      last_acc1   = req1_ready;
      last_cancel = div_cancel;
      if (div_req) seen_div_req = 1'b1;
      if (req0_ready) begin glog.push_back(0); gcyc.push_back(cyc); end
      if (req1_ready) begin glog.push_back(1); gcyc.push_back(cyc); end
      if (resp_valid) n_rv++;
      if (resp_valid && resp_ready && !flush) begin
         n_resp++;
         hcyc.push_back(cyc);
      end
      ref_step();
      @(posedge clk);
      #1;
      cyc++;
      if (fired) begin
         flush = 1'b0;
         hook_fired = 1'b1;
      end
   endtask

   task automatic drain();
      int n;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      resp_ready = 1'b1;
      n = 0;
      while (busy && n < LIMIT) begin tick(); n++; end
      chk("drain_budget", n < LIMIT, 1);
   endtask

   task automatic run_one(input int slot, input logic sgn, input logic [31:0] x, input logic [31:0] y,
                          input logic [TAG_W-1:0] tag, output logic [31:0] q, output logic [31:0] r,
                          output logic src, output logic [TAG_W-1:0] tg, output int nacc);
      int n;
      q = '0; r = '0; src = 1'b0; tg = '0;
      resp_ready = 1'b0;
      req0_valid = (slot == 0);
      req1_valid = (slot == 1);
      if (slot == 0) begin req0_signed = sgn; req0_x = x; req0_y = y; req0_tag = tag; end
      else begin req1_signed = sgn; req1_x = x; req1_y = y; req1_tag = tag; end
      n = 0;
      do begin tick(); n++; end while (!(slot == 1 ? last_acc1 : last_acc0) && n < LIMIT);
      nacc = n;
      chk("run_accept_budget", n < LIMIT, 1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < LIMIT) begin tick(); n++; end
      chk("run_resp_budget", n < LIMIT, 1);
      q = resp_quot; r = resp_rem; src = resp_src; tg = resp_tag;
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 3))
         0: rand_val = 32'($urandom_range(0, 20));
         1: rand_val = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
         default: rand_val = $urandom;
      endcase
   endfunction

   initial begin
      vec_t tbl [8];
      logic [31:0] q, r;
      logic s;
      logic [TAG_W-1:0] t;
      int n, nacc, op0, n_rv0, n_resp0, exp_ops;

      tbl[0] = '{0, 1'b0, 32'd100,        32'd7,          4'd3,  32'd14,         32'd2};
      tbl[1] = '{1, 1'b1, 32'hFFFF_FFF9,  32'd2,          4'd5,  32'hFFFF_FFFD,  32'hFFFF_FFFF};
      tbl[2] = '{0, 1'b0, 32'hFFFF_FFF9,  32'd2,          4'd9,  32'h7FFF_FFFC,  32'd1};
      tbl[3] = '{1, 1'b1, 32'd7,          32'hFFFF_FFFE,  4'd0,  32'hFFFF_FFFD,  32'd1};
      tbl[4] = '{0, 1'b1, 32'hFFFF_FF9C,  32'd7,          4'd15, 32'hFFFF_FFF2,  32'hFFFF_FFFE};
      tbl[5] = '{1, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd6,  32'd1,          32'd0};
      tbl[6] = '{0, 1'b0, 32'd0,          32'd5,          4'd1,  32'd0,          32'd0};
      tbl[7] = '{1, 1'b0, 32'd5,          32'd0,          4'd2,  32'hFFFF_FFFF,  32'd5};

      n_vec = 0; n_err = 0; cyc = 0;
      dv_busy = 0; force_data_ok = 0; dv_cnt = 0; dv_lat = 4; dv_acc_delay = 0; dv_wait = 0; n_opok = 0;
      rm_active = 0; rm_issued = 0; rm_have = 0; rm_rr = 0; rm_src = 0; rm_sgn = 0;
      rm_x = '0; rm_y = '0; rm_q = '0; rm_r = '0; rm_tag = '0;
      flush_on_data = 0; flush_on_done = 0; hook_fired = 0;
      last_acc0 = 0; last_acc1 = 0; last_cancel = 0; seen_div_req = 0; n_rv = 0; n_resp = 0;
      rst = 1'b0; flush = 1'b0; resp_ready = 1'b0;
      req0_valid = 0; req0_signed = 0; req0_x = '0; req0_y = '0; req0_tag = '0;
      req1_valid = 0; req1_signed = 0; req1_x = '0; req1_y = '0; req1_tag = '0;
      div_oprand_ok = 0; div_data_ok = 0; div_quot = '0; div_rem = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_div_req", div_req, 0);
      chk("rst_div_signed", div_signed, 0);
      chk("rst_div_x", div_x, 0);
      chk("rst_div_y", div_y, 0);
      chk("rst_div_cancel", div_cancel, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_src", resp_src, 0);
      chk("rst_resp_tag", resp_tag, 0);
      chk("rst_resp_quot", resp_quot, 0);
      chk("rst_resp_rem", resp_rem, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b1;

      // Both slots requesting continuously from reset: 0,1,0,1 with one bubble each.
      req0_valid = 1; req0_signed = 0; req0_x = 32'd20; req0_y = 32'd3; req0_tag = 4'd1;
      req1_valid = 1; req1_signed = 1; req1_x = 32'hFFFF_FFF7; req1_y = 32'd2; req1_tag = 4'd2;
      resp_ready = 1; dv_lat = 4;
      n = 0;
      while (glog.size() < 4 && n < LIMIT) begin tick(); n++; end
      chk("rr_grant_budget", n < LIMIT, 1);
      drain();
      for (int k = 0; k < 4; k++) begin
         if (k < glog.size()) chk($sformatf("rr_grant_order%0d", k), glog[k], k % 2);
      end
      for (int k = 1; k < 4; k++) begin
         if (k < gcyc.size() && k - 1 < hcyc.size())
            chk($sformatf("rr_bubble%0d", k), gcyc[k], hcyc[k-1] + 1);
      end

      // Table of single requests.
      for (int i = 0; i < 8; i++) begin
         dv_lat = (i == 0) ? 32 : 2 + i;
         op0 = n_opok;
         seen_div_req = 0;
         run_one(tbl[i].slot, tbl[i].sgn, tbl[i].x, tbl[i].y, tbl[i].tag, q, r, s, t, nacc);
         chk($sformatf("vec%0d_quot", i), q, tbl[i].q);
         chk($sformatf("vec%0d_rem", i), r, tbl[i].r);
         chk($sformatf("vec%0d_src", i), s, tbl[i].slot);
         chk($sformatf("vec%0d_tag", i), t, tbl[i].tag);
         chk($sformatf("vec%0d_accept_cycles", i), nacc, 1);
`ifdef DIV_ZERO_BYPASS_EN
         exp_ops = (tbl[i].y == 32'd0) ? 0 : 1;
`else
         exp_ops = 1;
`endif
         chk($sformatf("vec%0d_div_handshakes", i), n_opok - op0, exp_ops);
         chk($sformatf("vec%0d_div_req_seen", i), seen_div_req, exp_ops);
      end

      // Flush ten cycles into BUSY.
      dv_lat = 32; resp_ready = 0;
      req0_valid = 1; req0_signed = 0; req0_x = 32'd1000; req0_y = 32'd10; req0_tag = 4'd7;
      op0 = n_opok;
      tick();
      req0_valid = 0;
      n = 0;
      while (n_opok == op0 && n < LIMIT) begin tick(); n++; end
      chk("flush_busy_budget", n < LIMIT, 1);
      repeat (10) tick();
      n_rv0 = n_rv;
      flush = 1;
      tick();
      flush = 0;
      chk("flush_cancel", last_cancel, 1);
      chk("flush_busy_after", busy, 0);
      tick();
      chk("flush_cancel_one_cycle", last_cancel, 0);
      repeat (30) tick();
      chk("flush_no_resp", n_rv - n_rv0, 0);
      run_one(1, 1'b0, 32'd77, 32'd5, 4'd4, q, r, s, t, nacc);
      chk("post_flush_quot", q, 32'd15);
      chk("post_flush_rem", r, 32'd2);
      chk("post_flush_src", s, 1);
      chk("post_flush_tag", t, 4'd4);

      // Flush coincident with the divider's result pulse.
      dv_lat = 5; n_rv0 = n_rv; hook_fired = 0; flush_on_data = 1;
      req1_valid = 1; req1_signed = 1; req1_x = 32'hFFFF_FFCE; req1_y = 32'd7; req1_tag = 4'd8;
      tick();
      req1_valid = 0;
      n = 0;
      while (!hook_fired && n < LIMIT) begin tick(); n++; end
      flush_on_data = 0;
      chk("fod_budget", n < LIMIT, 1);
      chk("fod_busy", busy, 0);
      repeat (3) tick();
      chk("fod_no_resp", n_rv - n_rv0, 0);

      // Flush coincident with resp_ready in DONE.
      dv_lat = 3; n_resp0 = n_resp; hook_fired = 0; flush_on_done = 1; resp_ready = 1;
      req0_valid = 1; req0_signed = 0; req0_x = 32'd50; req0_y = 32'd6; req0_tag = 4'd11;
      tick();
      req0_valid = 0;
      n = 0;
      while (!hook_fired && n < LIMIT) begin tick(); n++; end
      flush_on_done = 0;
      chk("fdone_budget", n < LIMIT, 1);
      chk("fdone_busy", busy, 0);
      chk("fdone_resp_valid", resp_valid, 0);
      chk("fdone_no_handshake", n_resp - n_resp0, 0);
      resp_ready = 0;

      // Hold the result for 20 cycles while slot 1 keeps requesting.
      dv_lat = 6;
      req0_valid = 1; req0_signed = 1; req0_x = 32'd1000; req0_y = 32'hFFFF_FFFD; req0_tag = 4'd10;
      tick();
      req0_valid = 0;
      n = 0;
      while (!resp_valid && n < LIMIT) begin tick(); n++; end
      chk("hold_budget", n < LIMIT, 1);
      chk("hold_quot_value", resp_quot, 32'hFFFF_FEB3);
      chk("hold_rem_value", resp_rem, 32'd1);
      q = resp_quot; r = resp_rem; t = resp_tag;
      req1_valid = 1; req1_signed = 0; req1_x = 32'd9; req1_y = 32'd4; req1_tag = 4'd12;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("hold_valid", resp_valid, 1);
         chk("hold_quot", resp_quot, q);
         chk("hold_rem", resp_rem, r);
         chk("hold_tag", resp_tag, t);
         chk("hold_req1_ready", last_acc1, 0);
      end
      resp_ready = 1;
      n = 0;
      do begin tick(); n++; end while (!last_acc1 && n < LIMIT);
      chk("hold_next_grant_cycles", n, 2);
      drain();

      // Stray result pulses outside BUSY are ignored.
      force_data_ok = 1;
      repeat (3) tick();
      force_data_ok = 0;
      chk("stray_busy", busy, 0);

      // Randomized traffic against the reference model.
      for (int c = 0; c < 400; c++) begin
         req0_valid  = 1'($urandom_range(0, 1));
         req0_signed = 1'($urandom_range(0, 1));
         req0_x      = rand_val();
         req0_y      = ($urandom_range(0, 7) == 0) ? 32'd0 : rand_val();
         req0_tag    = TAG_W'($urandom_range(0, 15));
         req1_valid  = 1'($urandom_range(0, 1));
         req1_signed = 1'($urandom_range(0, 1));
         req1_x      = rand_val();
         req1_y      = ($urandom_range(0, 7) == 0) ? 32'd0 : rand_val();
         req1_tag    = TAG_W'($urandom_range(0, 15));
         resp_ready  = 1'($urandom_range(0, 1));
         flush       = ($urandom_range(0, 29) == 0);
         dv_lat      = $urandom_range(0, 5);
         dv_acc_delay = $urandom_range(0, 2);
         tick();
      end
      flush = 0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
